clk_reset_gen: RTL and testbench

Parametrised clock and reset generator for the 8085 system top level. Divides the crystal input into two non-overlapping phases `phi1`/`phi2` plus `clk_out`, with configurable division ratio and dead band. Synchronises and stretches the external `resetn_in` into the core reset `reset` and the peripheral reset `reset_out`. Supersedes the fixed divide-by-2 clock logic in the `system` top.

---
 rtl/clk_reset_gen.sv | 144 ++++++++++++++
 tb/tb_clk_reset_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_reset_gen.sv
// Crystal divider producing non-overlapping phi1/phi2, clk_out and period_start, plus a
// synchronised, stretched core/peripheral reset. Define CLKGEN_STOP_EN for stop_req/stop_ack.
module clk_reset_gen #(
  parameter int unsigned DIV           = 2,
  parameter int unsigned DEAD          = 0,
  parameter int unsigned RESET_STRETCH = 3
) (
  input  logic x1,
  input  logic resetn_in,
`ifdef CLKGEN_STOP_EN
  input  logic stop_req,
  output logic stop_ack,
`endif
  output logic phi1,
  output logic phi2,
  output logic clk_out,
  output logic period_start,
  output logic reset,
  output logic reset_out
);

  localparam int unsigned H  = DIV / 2;
  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned SW = (RESET_STRETCH > 1) ? $clog2(RESET_STRETCH + 1) : 1;

  localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
  localparam logic [SW-1:0] StLast  = SW'(RESET_STRETCH - 1);
  localparam logic [SW-1:0] StMax   = SW'(RESET_STRETCH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic [1:0]    sync_q;
  logic          sync;
  logic [SW-1:0] st_q, st_d;
  logic          reset_q, reset_d;
  logic          reset_out_q, reset_out_d;
  logic          phi1_q, phi1_d;
  logic          phi2_q, phi2_d;
  logic          clk_out_q, clk_out_d;
  logic          period_start_q, period_start_d;
  logic          period_end;
  logic          stopped;
  logic          stop_go;
  int unsigned   k;

  assign sync       = sync_q[1];
  assign period_end = (cnt_q == CntLast);

`ifdef CLKGEN_STOP_EN
  typedef enum logic {StRun, StStopped} stop_state_e;

  stop_state_e state_q;
  logic        stop_ack_q;

  assign stopped = (state_q == StStopped);
  // Stop only takes effect at a period boundary once the core is out of reset.
  assign stop_go = stopped ? stop_req : (stop_req && period_end && !reset_q);

  always_ff @(posedge x1 or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q    <= StRun;
      stop_ack_q <= 1'b0;
    end else begin
      state_q    <= stop_go ? StStopped : StRun;
      stop_ack_q <= stop_go;
    end
  end

  assign stop_ack = stop_ack_q;
`else
  assign stopped = 1'b0;
  assign stop_go = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    // The first edge after release (and every stopped edge) produces a cnt==0 cycle.
    if (!run_q || stopped || period_end) begin
      cnt_d = '0;
    end

    k              = 32'(cnt_d);
    phi1_d         = !stop_go && (k < H - DEAD);
    phi2_d         = !stop_go && (k >= H) && (k < DIV - DEAD);
    clk_out_d      = !stop_go && (k >= H);
    period_start_d = !stop_go && (k == 0);

    st_d = st_q;
    if (sync && period_end && (st_q != StMax)) begin
      st_d = st_q + SW'(1);
    end

    reset_d = reset_q;
    if (sync && period_end && (st_q == StLast)) begin
      reset_d = 1'b0;
    end

    reset_out_d = reset_out_q;
    if (!reset_q && period_end) begin
      reset_out_d = 1'b0;
    end
  end

  // Reset synchroniser and run flag; nothing but constant 1 feeds their D inputs.
  always_ff @(posedge x1 or negedge resetn_in) begin
    if (!resetn_in) begin
      sync_q <= 2'b00;
      run_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      run_q  <= 1'b1;
    end
  end

  always_ff @(posedge x1 or negedge resetn_in) begin
    if (!resetn_in) begin
      cnt_q          <= '0;
      st_q           <= '0;
      reset_q        <= 1'b1;
      reset_out_q    <= 1'b1;
      phi1_q         <= 1'b0;
      phi2_q         <= 1'b0;
      clk_out_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      st_q           <= st_d;
      reset_q        <= reset_d;
      reset_out_q    <= reset_out_d;
      phi1_q         <= phi1_d;
      phi2_q         <= phi2_d;
      clk_out_q      <= clk_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign phi1         = phi1_q;
  assign phi2         = phi2_q;
  assign clk_out      = clk_out_q;
  assign period_start = period_start_q;
  assign reset        = reset_q;
  assign reset_out    = reset_out_q;

endmodule

// File: tb/tb_clk_reset_gen.sv
// Randomised scoreboard bench for clk_reset_gen: four configurations share the crystal and
// reset; a period-level reference model predicts every output each cycle.
module tb_clk_reset_gen;

  localparam int NI   = 4;
  localparam int NCYC = 3000;
  localparam int VW   = 7;

  function automatic int div_of(input int g);
    int r;
    case (g)
      0:       r = 8;
      1:       r = 2;
      2:       r = 6;
      default: r = 4;
    endcase
    return r;
  endfunction

  function automatic int dead_of(input int g);
    int r;
    case (g)
      0:       r = 1;
      1:       r = 0;
      2:       r = 2;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int rs_of(input int g);
    int r;
    case (g)
      0:       r = 1;
      1:       r = 3;
      2:       r = 2;
      default: r = 2;
    endcase
    return r;
  endfunction

  logic          x1 = 1'b0;
  logic          resetn_in;
  logic [NI-1:0] phi1_w, phi2_w, clk_out_w, period_start_w, reset_w, reset_out_w, stop_ack_w;
  logic [VW-1:0] obs [NI];
`ifdef CLKGEN_STOP_EN
  logic [NI-1:0] stop_req;
`endif

  always #5 x1 = ~x1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    clk_reset_gen #(
      .DIV          (div_of(g)),
      .DEAD         (dead_of(g)),
      .RESET_STRETCH(rs_of(g))
    ) u_dut (
      .x1          (x1),
      .resetn_in   (resetn_in),
`ifdef CLKGEN_STOP_EN
      .stop_req    (stop_req[g]),
      .stop_ack    (stop_ack_w[g]),
`endif
      .phi1        (phi1_w[g]),
      .phi2        (phi2_w[g]),
      .clk_out     (clk_out_w[g]),
      .period_start(period_start_w[g]),
      .reset       (reset_w[g]),
      .reset_out   (reset_out_w[g])
    );
    assign obs[g] = {phi1_w[g], phi2_w[g], clk_out_w[g], period_start_w[g],
                     reset_w[g], reset_out_w[g], stop_ack_w[g]};
  end

`ifndef CLKGEN_STOP_EN
  assign stop_ack_w = '0;
`endif

  // Reference model: edges seen since release, position within the period, completed
  // periods with the synchroniser up, periods finished after the core reset dropped.
  int m_edges   [NI];
  int m_pos     [NI];
  int m_periods [NI];
  int m_after   [NI];
  bit m_stopped [NI];

  logic [VW*NI-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic model_reset(input int g);
    m_edges[g]   = 0;
    m_pos[g]     = 0;
    m_periods[g] = 0;
    m_after[g]   = 0;
    m_stopped[g] = 1'b0;
  endtask

  task automatic model_edge(input int g, input logic sreq);
    bit sync_up  = (m_edges[g] >= 2);
    bit pend     = (m_edges[g] >= 1) && !m_stopped[g] && (m_pos[g] == div_of(g) - 1);
    bit core_rst = (m_periods[g] < rs_of(g));
    bit go       = m_stopped[g] ? (sreq == 1'b1) : ((sreq == 1'b1) && pend && !core_rst);
    if (sync_up && pend) m_periods[g]++;
    if (pend && !core_rst) m_after[g]++;
    if (m_edges[g] == 0 || m_stopped[g]) m_pos[g] = 0;
    else m_pos[g] = (m_pos[g] + 1) % div_of(g);
    if (m_edges[g] < 2) m_edges[g]++;
    m_stopped[g] = go;
  endtask

  function automatic logic [VW-1:0] model_out(input int g);
    int h = div_of(g) / 2;
    int d = div_of(g);
    int dd = dead_of(g);
    int p = m_pos[g];
    bit on = (m_edges[g] > 0) && !m_stopped[g];
    logic [VW-1:0] v;
    v[6] = on && (p < h - dd);
    v[5] = on && (p >= h) && (p < d - dd);
    v[4] = on && (p >= h);
    v[3] = on && (p == 0);
    v[2] = (m_periods[g] < rs_of(g));
    v[1] = (m_after[g] == 0);
    v[0] = m_stopped[g];
    return v;
  endfunction

  task automatic drive();
    int low_left = 3;
    int idx;
    bit pulse;
    logic [VW*NI-1:0] e;
    logic [VW-1:0] rv;
`ifdef CLKGEN_STOP_EN
    logic [NI-1:0] sreq = '1;
`else
    logic [NI-1:0] sreq = '0;
`endif
    resetn_in = 1'b0;
`ifdef CLKGEN_STOP_EN
    stop_req = sreq;
`endif
    for (int g = 0; g < NI; g++) model_reset(g);
    for (int c = 0; c < NCYC; c++) begin
      if (c > 0) begin
        @(posedge x1);
        #2;
      end
      pulse = 1'b0;
      if (low_left == 0 && c >= 1200 && $urandom_range(0, 299) == 0) begin
        low_left = $urandom_range(1, 4);
      end
      if (low_left == 0 && (c == 1150 || (c >= 1200 && $urandom_range(0, 149) == 0))) begin
        pulse = 1'b1;
      end
`ifdef CLKGEN_STOP_EN
      if (c == 60) begin
        sreq = '0;
      end else if (c > 1100 && $urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, NI - 1);
        sreq[idx] = ~sreq[idx];
      end
      stop_req = sreq;
`else
      idx = 0;
`endif
      if (low_left > 0) begin
        resetn_in = 1'b0;
        low_left--;
        for (int g = 0; g < NI; g++) model_reset(g);
      end else begin
        if (pulse) begin
          resetn_in = 1'b0;
          for (int g = 0; g < NI; g++) model_reset(g);
          #1;
          for (int g = 0; g < NI; g++) begin
            rv = model_out(g);
            checks++;
            if (obs[g] !== rv) begin
              errors++;
              $display("FAIL pulse_clear inst%0d cycle %0d: got %b, required %b", g, c, obs[g],
                       rv);
            end
          end
          #2;
        end
        resetn_in = 1'b1;
        for (int g = 0; g < NI; g++) model_edge(g, sreq[g]);
      end
      for (int g = 0; g < NI; g++) e[g*VW +: VW] = model_out(g);
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    logic [VW*NI-1:0] e;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge x1);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: got an empty queue, required an expected entry", c);
      end else begin
        e = exp_q.pop_front();
        for (int g = 0; g < NI; g++) begin
          checks++;
          if (obs[g] !== e[g*VW +: VW]) begin
            errors++;
            $display("FAIL outputs inst%0d cycle %0d: got %b, required %b (phi1 phi2 clk_out %s",
                     g, c, obs[g], e[g*VW +: VW], "period_start reset reset_out stop_ack)");
          end
          checks++;
          if ((phi1_w[g] & phi2_w[g]) !== 1'b0) begin
            errors++;
            $display("FAIL overlap inst%0d cycle %0d: got phi1&phi2=%b, required 0", g, c,
                     phi1_w[g] & phi2_w[g]);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      drive();
      monitor();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
